mem_access_unit: RTL

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register and feeding the MEM/WB register. It performs RV32I byte/half/word loads and stores (func3-encoded) over a req/gnt/rvalid data-memory bus, formats load data with sign/zero extension, and raises a stall to freeze upstream stages while a bus transaction is outstanding. Alignment and illegal-encoding errors are flagged without issuing a bus access.

---
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: RV32I loads/stores over a req/gnt/rvalid bus,
// with load formatting, upstream stall and alignment/encoding error flagging.
package mau_pkg;
    typedef logic [4:0] regName_t;
endpackage

module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              memWrite_MEM_In,
    input  logic              memRead_MEM_In,
    input  logic              regWrite_MEM_In,
    input  logic              memToRegWrite_MEM_In,
    input  logic [2:0]        func3_MEM_In,
    input  logic [31:0]       aluOut_MEM_In,
    input  logic [31:0]       aluSrc2_MEM_In,
    input  regName_t          rd_MEM_In,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [ADDR_W-1:0] dmemAddr,
    output logic [3:0]        dmemBe,
    output logic [31:0]       dmemWdata,
    input  logic              dmemGnt,
    input  logic              dmemRvalid,
    input  logic [31:0]       dmemRdata,
    output logic              stallMEM,
    output logic              memErr,
    output logic              regWrite_MEM_Out,
    output logic              memToRegWrite_MEM_Out,
    output logic [31:0]       aluOut_MEM_Out,
    output regName_t          rd_MEM_Out,
    output logic [31:0]       loadData_MEM_Out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

    state_t      state;
    logic [31:0] load_q;
    logic        legal_f3;
    logic        aligned;
    logic        access;
    logic        issue;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] fmt;

    always_comb begin
        legal_f3 = 1'b0;
        case (func3_MEM_In)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = memRead_MEM_In;
            default:                legal_f3 = 1'b0;
        endcase
        aligned = 1'b1;
        case (func3_MEM_In[1:0])
            2'b01:   aligned = ~aluOut_MEM_In[0];
            2'b10:   aligned = (aluOut_MEM_In[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        access = (memRead_MEM_In ^ memWrite_MEM_In) & legal_f3 & aligned;
    end

    // rstN gating makes the request and stall drop the moment reset asserts
    assign issue    = rstN & ((state == IDLE && access) || state == REQ);
    assign dmemReq  = issue;
    assign stallMEM = rstN & ((state == IDLE && access) ||
                              state == REQ || state == WAIT_RD);
    assign memErr   = rstN & (state == IDLE) &
                      (memRead_MEM_In | memWrite_MEM_In) & ~access;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = aluSrc2_MEM_In;
        if (memWrite_MEM_In) begin
            case (func3_MEM_In[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << aluOut_MEM_In[1:0];
                    wdata_c = {4{aluSrc2_MEM_In[7:0]}};
                end
                2'b01: begin
                    be_c    = aluOut_MEM_In[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{aluSrc2_MEM_In[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = aluSrc2_MEM_In;
                end
            endcase
        end
    end

    assign dmemAddr  = {aluOut_MEM_In[ADDR_W-1:2], 2'b00};
    assign dmemWe    = issue & memWrite_MEM_In;
    assign dmemBe    = issue ? be_c : 4'b0000;
    assign dmemWdata = issue ? wdata_c : 32'h0;

    always_comb begin
        shifted = dmemRdata >> {aluOut_MEM_In[1:0], 3'b000};
        half    = aluOut_MEM_In[1] ? dmemRdata[31:16] : dmemRdata[15:0];
        case (func3_MEM_In)
            3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  fmt = {{16{half[15]}}, half};
            3'b100:  fmt = {24'h0, shifted[7:0]};
            3'b101:  fmt = {16'h0, half};
            default: fmt = dmemRdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= IDLE;
            load_q <= 32'h0;
        end else begin
            case (state)
                IDLE, REQ: begin
                    if (state == REQ || access) begin
                        if (dmemGnt)
                            state <= memRead_MEM_In ? WAIT_RD : DONE;
                        else
                            state <= REQ;
                    end
                end
                WAIT_RD: begin
                    if (dmemRvalid) begin
                        load_q <= fmt;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign regWrite_MEM_Out      = regWrite_MEM_In & ~memErr;
    assign memToRegWrite_MEM_Out = memToRegWrite_MEM_In;
    assign aluOut_MEM_Out        = aluOut_MEM_In;
    assign rd_MEM_Out            = rd_MEM_In;
    assign loadData_MEM_Out      = load_q;

endmodule
